// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes plus command/response records
// used by masters and by the benches that drive them.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef struct packed {
    logic                  write;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
  } axi_lite_cmd_t;

  typedef struct packed {
    logic                  write;
    logic [AXI_DATA_W-1:0] rdata;
    resp_t                 resp;
  } axi_lite_rsp_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle carrying all five channels (AR, R, AW, W, B).
interface axi_lite_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  resp_t                 bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI read
// or write and returns a registered response record.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi_lite_if.master              axim
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  resp_t                 r_rsp_resp;

  logic                  w_accept;
  logic                  w_ar_hs;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_done_nxt;
  logic                  w_w_done_nxt;

  // cmd_ready is the only output decoded straight from state.
  assign cmd_ready = (r_state == IDLE) && !areset;
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_ar_hs = r_arvalid && axim.arready;
  assign w_aw_hs = r_awvalid && axim.awready;
  assign w_w_hs  = r_wvalid  && axim.wready;

  // Done flags include this cycle's handshake so simultaneous AW/W completes at once.
  assign w_aw_done_nxt = (r_state == WR_REQ) && (r_aw_done || w_aw_hs);
  assign w_w_done_nxt  = (r_state == WR_REQ) && (r_w_done  || w_w_hs);

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = cmd_write ? WR_REQ : RD_ADDR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          w_state_nxt = RD_DATA;
        end else begin
          w_state_nxt = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (axim.rvalid) begin
          w_state_nxt = RSP;
        end else begin
          w_state_nxt = RD_DATA;
        end
      end
      WR_REQ: begin
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = WR_RESP;
        end else begin
          w_state_nxt = WR_REQ;
        end
      end
      WR_RESP: begin
        if (axim.bvalid) begin
          w_state_nxt = RSP;
        end else begin
          w_state_nxt = WR_RESP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RSP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Channel valids/readies are registered from the next state so they line up with it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_arvalid   <= (w_state_nxt == RD_ADDR);
      r_rready    <= (w_state_nxt == RD_DATA);
      r_awvalid   <= (w_state_nxt == WR_REQ) && !w_aw_done_nxt;
      r_wvalid    <= (w_state_nxt == WR_REQ) && !w_w_done_nxt;
      r_bready    <= (w_state_nxt == WR_RESP);
      r_aw_done   <= (w_state_nxt == WR_REQ) && w_aw_done_nxt;
      r_w_done    <= (w_state_nxt == WR_REQ) && w_w_done_nxt;
      r_rsp_valid <= (w_state_nxt == RSP);
    end
  end

  // Command latch and response capture.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_write     <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_wstrb     <= {STRB_WIDTH{1'b0}};
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_resp  <= OKAY;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_wstrb <= cmd_wstrb;
      end
      if ((r_state == RD_DATA) && axim.rvalid) begin
        r_rsp_write <= r_write;
        r_rsp_rdata <= axim.rdata;
        r_rsp_resp  <= axim.rresp;
      end else if ((r_state == WR_RESP) && axim.bvalid) begin
        r_rsp_write <= r_write;
        r_rsp_rdata <= {DATA_WIDTH{1'b0}};
        r_rsp_resp  <= axim.bresp;
      end
    end
  end

  assign axim.araddr  = r_addr;
  assign axim.arprot  = 3'b000;
  assign axim.arvalid = r_arvalid;
  assign axim.rready  = r_rready;
  assign axim.awaddr  = r_addr;
  assign axim.awprot  = 3'b000;
  assign axim.awvalid = r_awvalid;
  assign axim.wdata   = r_wdata;
  assign axim.wstrb   = r_wstrb;
  assign axim.wvalid  = r_wvalid;
  assign axim.bready  = r_bready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small decoding slave model that
// stands in for the interconnect and its slaves.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axim ();

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axim      (axim)
  );

  // Slave model: AR always ready, AW/W ready after programmable waits, B can be stalled.
  int unsigned   aw_delay = 0;
  int unsigned   w_delay  = 0;
  bit            b_stall  = 1'b0;
  int unsigned   aw_cnt, w_cnt;
  logic          s_aw_got, s_w_got, s_b_pend, s_rvalid;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_rdata;
  resp_t         s_rresp;
  logic          s_aw_hs, s_w_hs;

  function automatic logic [DW-1:0] slv_rdata(input logic [AW-1:0] a);
    case (a)
      32'h0000_0000: return 32'h1111_1111;
      32'h0000_0004: return 32'hDEAD_BEEF;
      32'h0000_0010: return 32'h2222_2222;
      32'h0000_0040: return 32'hBAD0_BAD0;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  function automatic resp_t slv_rresp(input logic [AW-1:0] a);
    return (a == 32'h0000_0040) ? DECERR : OKAY;
  endfunction

  assign axim.arready = 1'b1;
  assign axim.awready = axim.awvalid && (aw_cnt == aw_delay);
  assign axim.wready  = axim.wvalid && (w_cnt == w_delay);
  assign axim.bvalid  = s_b_pend && !b_stall;
  assign axim.bresp   = (s_awaddr == 32'h0000_0048) ? SLVERR : OKAY;
  assign axim.rvalid  = s_rvalid;
  assign axim.rdata   = s_rdata;
  assign axim.rresp   = s_rresp;
  assign s_aw_hs      = axim.awvalid && axim.awready;
  assign s_w_hs       = axim.wvalid && axim.wready;

  always @(posedge aclk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_b_pend <= 1'b0; s_rvalid <= 1'b0;
      s_awaddr <= '0; s_rdata <= '0; s_rresp <= OKAY;
    end else begin
      if (axim.arvalid && axim.arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= slv_rdata(axim.araddr);
        s_rresp  <= slv_rresp(axim.araddr);
      end else if (s_rvalid && axim.rready) begin
        s_rvalid <= 1'b0;
      end
      aw_cnt <= (axim.awvalid && !axim.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axim.wvalid && !axim.wready) ? w_cnt + 1 : 0;
      if (s_aw_hs) s_awaddr <= axim.awaddr;
      if ((s_aw_got || s_aw_hs) && (s_w_got || s_w_hs)) begin
        s_b_pend <= 1'b1;
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end else begin
        s_aw_got <= s_aw_got || s_aw_hs;
        s_w_got  <= s_w_got || s_w_hs;
        if (axim.bvalid && axim.bready) s_b_pend <= 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic axi_lite_cmd_t rd_cmd(input logic [AW-1:0] a);
    return axi_lite_cmd_t'{write: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0};
  endfunction

  function automatic axi_lite_cmd_t wr_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                           input logic [3:0] s);
    return axi_lite_cmd_t'{write: 1'b1, addr: a, wdata: d, wstrb: s};
  endfunction

  // Called at a falling edge; returns at the falling edge one cycle after acceptance.
  task automatic issue(input axi_lite_cmd_t c);
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_wstrb = c.wstrb;
    cmd_valid = 1'b1;
    #1;
    check_val("accept_rdy", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge aclk);
      lat++;
    end
  endtask

  task automatic expect_rsp(input string tag, input logic wr, input logic [DW-1:0] d,
                            input resp_t r);
    check_val({tag, "_write"}, 64'(rsp_write), 64'(wr));
    check_val({tag, "_rdata"}, 64'(rsp_rdata), 64'(d));
    check_val({tag, "_resp"},  64'(rsp_resp),  64'(r));
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 1'b0;
    #1;
    check_val("rsp_drop", 64'(rsp_valid), 64'd0);
    check_val("idle_rdy", 64'(cmd_ready), 64'd1);
  endtask

  function automatic logic [5:0] hs_vec();
    return {axim.arvalid, axim.awvalid, axim.wvalid, axim.rready, axim.bready, rsp_valid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;

    // Reset state.
    repeat (3) @(negedge aclk);
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_val("rst_valids", 64'(hs_vec()), 64'd0);
    check_val("rst_rdata", 64'(rsp_rdata), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check_val("post_rst_rdy", 64'(cmd_ready), 64'd1);

    // Zero-wait read of 0x04.
    issue(rd_cmd(32'h04));
    check_val("rd_arvalid", 64'(axim.arvalid), 64'd1);
    check_val("rd_araddr", 64'(axim.araddr), 64'h04);
    check_val("rd_busy_rdy", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    check_val("rd_ar_drop", 64'(axim.arvalid), 64'd0);
    check_val("rd_rready", 64'(axim.rready), 64'd1);
    wait_rsp(2, lat);
    check_val("rd_lat", 64'(lat), 64'd3);
    expect_rsp("rd04", 1'b0, 32'hDEAD_BEEF, OKAY);
    consume();

    // Write with AW delayed two cycles and W immediate.
    aw_delay = 2;
    issue(wr_cmd(32'h14, 32'hA5A5_A5A5, 4'hF));
    check_val("wr_both_valid", 64'({axim.awvalid, axim.wvalid}), 64'd3);
    check_val("wr_wdata", 64'(axim.wdata), 64'hA5A5_A5A5);
    check_val("wr_wstrb", 64'(axim.wstrb), 64'hF);
    @(negedge aclk);
    check_val("wr_w_drop", 64'({axim.awvalid, axim.wvalid}), 64'd2);
    @(negedge aclk);
    check_val("wr_aw_held", 64'(axim.awvalid), 64'd1);
    check_val("wr_awaddr", 64'(axim.awaddr), 64'h14);
    wait_rsp(3, lat);
    check_val("wr_lat", 64'(lat), 64'd5);
    expect_rsp("wr14", 1'b1, 32'h0, OKAY);
    consume();
    aw_delay = 0;

    // Zero-wait write with simultaneous AW/W handshakes and SLVERR forwarded.
    issue(wr_cmd(32'h48, 32'h1234_5678, 4'h3));
    wait_rsp(1, lat);
    check_val("wr0_lat", 64'(lat), 64'd3);
    expect_rsp("wr48", 1'b1, 32'h0, SLVERR);
    consume();

    // Unmapped read returns DECERR with the slave's data.
    issue(rd_cmd(32'h40));
    wait_rsp(1, lat);
    check_val("dec_lat", 64'(lat), 64'd3);
    expect_rsp("rd40", 1'b0, 32'hBAD0_BAD0, DECERR);
    consume();

    // Back-to-back reads with a stalled response in between.
    issue(rd_cmd(32'h00));
    cmd_addr  = 32'h10;
    cmd_valid = 1'b1;
    wait_rsp(1, lat);
    check_val("b2b1_lat", 64'(lat), 64'd3);
    expect_rsp("rd00", 1'b0, 32'h1111_1111, OKAY);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_val("hold_vld_rdy", 64'({rsp_valid, cmd_ready}), 64'd2);
      check_val("hold_rdata", 64'(rsp_rdata), 64'h1111_1111);
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 1'b0;
    #1;
    check_val("b2b_rsp_drop", 64'(rsp_valid), 64'd0);
    check_val("b2b_rdy", 64'(cmd_ready), 64'd1);
    check_val("b2b_not_early", 64'(axim.arvalid), 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    check_val("b2b_arvalid", 64'(axim.arvalid), 64'd1);
    check_val("b2b_araddr", 64'(axim.araddr), 64'h10);
    wait_rsp(1, lat);
    check_val("b2b2_lat", 64'(lat), 64'd3);
    expect_rsp("rd10", 1'b0, 32'h2222_2222, OKAY);
    consume();

    // Reset while waiting in WR_RESP, then a normal write.
    b_stall = 1'b1;
    issue(wr_cmd(32'h20, 32'hCAFE_F00D, 4'hF));
    k = 0;
    while (axim.bready !== 1'b1 && k < 20) begin
      @(negedge aclk);
      k++;
    end
    check_val("wresp_reached", 64'(axim.bready), 64'd1);
    areset = 1'b1;
    #1;
    check_val("rst_mid_rdy", 64'(cmd_ready), 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    areset  = 1'b0;
    b_stall = 1'b0;
    #1;
    check_val("rst_mid_valids", 64'(hs_vec()), 64'd0);
    check_val("rst_mid_idle", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    issue(wr_cmd(32'h24, 32'h0BAD_CAFE, 4'h1));
    wait_rsp(1, lat);
    check_val("post_rst_lat", 64'(lat), 64'd3);
    expect_rsp("wr24", 1'b1, 32'h0, OKAY);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
